// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
// Purpose: FSM state enum, jump code constant, freeze/flush control bundle.
// Ports: none (package pipe_ctrl_pkg).
package pipe_ctrl_pkg;

   localparam int DEF_REG_ADDR_W = 5;

   localparam logic [1:0] JUMP_NONE = 2'b00;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      MISS   = 2'd1,
      REFILL = 2'd2
   } state_t;

   typedef struct packed {
      logic freeze_pc;
      logic freeze_if_id;
      logic freeze_id_exe;
      logic freeze_exe_mem;
      logic flush_if_id;
      logic flush_id_exe;
      logic flush_mem_wb;
   } ctl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
// Purpose: groups the ID/EXE/MEM observation inputs and freeze/flush/error outputs.
// Ports (modport slave = controller side):
//   in : id_rs, id_rt, id_uses_rt, exe_mem_to_reg, exe_reg_write, exe_rd, exe_jump,
//        mem_cache_miss, mem_ready
//   out: freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem,
//        flush_if_id, flush_id_exe, flush_mem_wb, miss_err
interface pipe_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5
);
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_uses_rt;
   logic                  exe_mem_to_reg;
   logic                  exe_reg_write;
   logic [REG_ADDR_W-1:0] exe_rd;
   logic [1:0]            exe_jump;
   logic                  mem_cache_miss;
   logic                  mem_ready;
   logic                  freeze_pc;
   logic                  freeze_if_id;
   logic                  freeze_id_exe;
   logic                  freeze_exe_mem;
   logic                  flush_if_id;
   logic                  flush_id_exe;
   logic                  flush_mem_wb;
   logic                  miss_err;

   modport master (
      output id_rs, id_rt, id_uses_rt, exe_mem_to_reg, exe_reg_write, exe_rd,
             exe_jump, mem_cache_miss, mem_ready,
      input  freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem,
             flush_if_id, flush_id_exe, flush_mem_wb, miss_err
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, exe_mem_to_reg, exe_reg_write, exe_rd,
             exe_jump, mem_cache_miss, mem_ready,
      output freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem,
             flush_if_id, flush_id_exe, flush_mem_wb, miss_err
   );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// rtl/pipe_hazard_ctrl_hazard_detect.sv - combinational load-use and jump detection
// Purpose: raw hazard compares, before any miss suppression or priority.
// Ports:
//   in : id_rs, id_rt, id_uses_rt, exe_mem_to_reg, exe_reg_write, exe_rd, exe_jump
//   out: load_use (EXE load feeds ID source), jump_taken (EXE redirect)
module hazard_detect_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic                  exe_mem_to_reg,
   input  logic                  exe_reg_write,
   input  logic [REG_ADDR_W-1:0] exe_rd,
   input  logic [1:0]            exe_jump,
   output logic                  load_use,
   output logic                  jump_taken
);
   logic load_in_exe;
   logic src_match;

   // r0 is hardwired zero, so a load targeting it never produces a dependence.
   assign load_in_exe = exe_mem_to_reg && exe_reg_write && (exe_rd != '0);
   assign src_match   = (exe_rd == id_rs) || (id_uses_rt && (exe_rd == id_rt));
   assign load_use    = load_in_exe && src_match;
   assign jump_taken  = (exe_jump != JUMP_NONE);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline registers
// Purpose: load-use stall, EXE jump flush, D-cache miss hold FSM with sticky watchdog.
// Ports:
//   clk, rst_b      : clock, synchronous active-low reset
//   bus (slave)     : hazard inputs and freeze/flush/miss_err outputs
//   perf_stall_cycles, perf_flush_count : saturating counters (HAZARD_PERF_EN only)
// Optional feature macro: HAZARD_PERF_EN
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
   parameter int MISS_TIMEOUT = 64,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_b,
   pipe_hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_stall_cycles,
   output logic [CNT_W-1:0] perf_flush_count
`endif
);
   state_t           state;
   logic [CNT_W-1:0] wd_cnt;
   logic             miss_err_q;
   logic             load_use;
   logic             jump_taken;
   logic             miss_hold;
   ctl_t             ctl;

   hazard_detect_unit #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_detect (
      .id_rs          (bus.id_rs),
      .id_rt          (bus.id_rt),
      .id_uses_rt     (bus.id_uses_rt),
      .exe_mem_to_reg (bus.exe_mem_to_reg),
      .exe_reg_write  (bus.exe_reg_write),
      .exe_rd         (bus.exe_rd),
      .exe_jump       (bus.exe_jump),
      .load_use       (load_use),
      .jump_taken     (jump_taken)
   );

   // The freeze starts in the very RUN cycle the miss appears, so the
   // missing access is never allowed to slip past MEM.
   assign miss_hold = (state != RUN) || bus.mem_cache_miss;

   always_comb begin
      ctl = '0;
      if (!rst_b) begin
         ctl = '0;
      end else if (miss_hold) begin
         ctl.freeze_pc      = 1'b1;
         ctl.freeze_if_id   = 1'b1;
         ctl.freeze_id_exe  = 1'b1;
         ctl.freeze_exe_mem = 1'b1;
         ctl.flush_mem_wb   = 1'b1;
      end else if (jump_taken) begin
         // ID holds a wrong-path instruction; stalling it would be pointless.
         ctl.flush_if_id  = 1'b1;
         ctl.flush_id_exe = 1'b1;
      end else if (load_use) begin
         ctl.freeze_pc    = 1'b1;
         ctl.freeze_if_id = 1'b1;
         ctl.flush_id_exe = 1'b1;
      end
   end

   assign bus.freeze_pc      = ctl.freeze_pc;
   assign bus.freeze_if_id   = ctl.freeze_if_id;
   assign bus.freeze_id_exe  = ctl.freeze_id_exe;
   assign bus.freeze_exe_mem = ctl.freeze_exe_mem;
   assign bus.flush_if_id    = ctl.flush_if_id;
   assign bus.flush_id_exe   = ctl.flush_id_exe;
   assign bus.flush_mem_wb   = ctl.flush_mem_wb;
   assign bus.miss_err       = miss_err_q;

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state      <= RUN;
         wd_cnt     <= '0;
         miss_err_q <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               wd_cnt <= '0;
               if (bus.mem_cache_miss) state <= MISS;
            end
            MISS: begin
               // wd_cnt counts completed MISS cycles; the error lands on the
               // edge that completes the MISS_TIMEOUT-th one.
               if (wd_cnt == CNT_W'(MISS_TIMEOUT - 1)) miss_err_q <= 1'b1;
               if (bus.mem_ready) begin
                  state  <= REFILL;
                  wd_cnt <= '0;
               end else if (wd_cnt != '1) begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            REFILL: begin
               wd_cnt <= '0;
               state  <= RUN;
            end
            default: begin
               wd_cnt <= '0;
               state  <= RUN;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   // flush_id_exe is only ever raised by a jump or a load-use, so it is
   // counted directly.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         perf_stall_cycles <= '0;
         perf_flush_count  <= '0;
      end else begin
         if (ctl.freeze_pc && (perf_stall_cycles != '1))
            perf_stall_cycles <= perf_stall_cycles + 1'b1;
         if (ctl.flush_id_exe && (perf_flush_count != '1))
            perf_flush_count <= perf_flush_count + 1'b1;
      end
   end
`endif

endmodule
